// File: rtl/audio_dac_pkg.sv
// Shared types and default sizing for the audio DAC digital controller.
package audio_dac_pkg;

  typedef enum logic [1:0] {
    UNMUTED   = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } mute_state_t;

  localparam int DEF_NCH      = 2;
  localparam int DEF_DW       = 24;
  localparam int DEF_GW       = 8;
  localparam int DEF_DIV_BITS = 10;

endpackage

// File: rtl/audio_dac_clk_en_gen.sv
// Free-running divider producing single-cycle enables at /8 .. /2^DIV_BITS,
// plus half-period-offset companions.
module audio_dac_clk_en_gen #(
  parameter  int DIV_BITS = 10,
  localparam int NEN      = DIV_BITS - 2
) (
  input  logic                clock,
  input  logic                rstn,
  output logic [DIV_BITS-1:0] div_cnt,
  output logic [NEN-1:0]      clk_en,
  output logic [NEN-1:0]      clk_en_neg
);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) div_cnt <= '0;
    else       div_cnt <= div_cnt + 1'b1;
  end

  // Decoded straight from the count so both strobes read 0 while in reset.
  for (genvar k = 0; k < NEN; k++) begin : g_en
    assign clk_en[k]     = &div_cnt[k+2:0];
    assign clk_en_neg[k] = ~div_cnt[k+2] & (&div_cnt[k+1:0]);
  end

endmodule

// File: rtl/audio_dac_dig_ctrl.sv
// Audio DAC digital controller: frame pacing, one-frame input buffer,
// click-free soft-mute gain ramp and DEM bypass select synchronisation.
//
// state     | meaning
// UNMUTED   | gain held at unity
// RAMP_DOWN | gain steps -1 per frame towards 0
// MUTED     | gain held at 0, muted asserted
// RAMP_UP   | gain steps +1 per frame towards unity
module audio_dac_dig_ctrl
  import audio_dac_pkg::*;
#(
  parameter  int NCH      = DEF_NCH,
  parameter  int DW       = DEF_DW,
  parameter  int DIV_BITS = DEF_DIV_BITS,
  parameter  int GW       = DEF_GW,
  localparam int NEN      = DIV_BITS - 2
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mute_req,
  input  logic                ISI_SEL,
  input  logic                MIS_SEL,
  output logic [NEN-1:0]      clk_en,
  output logic [NEN-1:0]      clk_en_neg,
  output logic [DIV_BITS-1:0] div_cnt,
  output logic [NCH*DW-1:0]   data_out,
  output logic                out_strobe,
  output logic                isi_sel_s,
  output logic                mis_sel_s,
  output logic                muted,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam logic [GW:0] UNITY    = {1'b1, {GW{1'b0}}};
  localparam logic [GW:0] GAIN_ONE = {{GW{1'b0}}, 1'b1};

  logic              fs;
  logic              fs_d;
  logic              rdy_en;
  logic              buf_full;
  logic [NCH*DW-1:0] buf_data;
  logic [NCH*DW-1:0] work;
  logic [NCH*DW-1:0] scaled;
  logic [GW:0]       gain;
  mute_state_t       state;
  logic              isi_m, isi_q, mis_m, mis_q;

  audio_dac_clk_en_gen #(.DIV_BITS(DIV_BITS)) u_clk_en_gen (
    .clock      (clock),
    .rstn       (rstn),
    .div_cnt    (div_cnt),
    .clk_en     (clk_en),
    .clk_en_neg (clk_en_neg)
  );

  assign fs       = clk_en[NEN-1];
  assign in_ready = rdy_en & ~buf_full;

  // in_ready is held low for the first cycle after reset release.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rdy_en       <= 1'b0;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      work         <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (fs && buf_full) begin
        work     <= buf_data;
        buf_full <= 1'b0;
      end else if (in_valid && in_ready) begin
        buf_data <= in_data;
        buf_full <= 1'b1;
      end
      if (fs && !buf_full) begin
        underrun <= 1'b1;
        if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state <= MUTED;
      gain  <= '0;
      muted <= 1'b1;
    end else begin
      case (state)
        UNMUTED: if (mute_req) state <= RAMP_DOWN;
        RAMP_DOWN: begin
          if (!mute_req) begin
            state <= RAMP_UP;
          end else if (fs) begin
            gain <= gain - 1'b1;
            if (gain == GAIN_ONE) begin
              state <= MUTED;
              muted <= 1'b1;
            end
          end
        end
        MUTED: begin
          if (!mute_req) begin
            state <= RAMP_UP;
            muted <= 1'b0;
          end
        end
        RAMP_UP: begin
          if (mute_req) begin
            // A ramp that has not yet left zero falls straight back to MUTED.
            if (gain == '0) begin
              state <= MUTED;
              muted <= 1'b1;
            end else begin
              state <= RAMP_DOWN;
            end
          end else if (fs) begin
            gain <= gain + 1'b1;
            if (gain == UNITY - 1'b1) state <= UNMUTED;
          end
        end
        default: begin
          state <= MUTED;
          gain  <= '0;
          muted <= 1'b1;
        end
      endcase
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_scale
    logic signed [DW+GW:0] prod;
    assign prod = $signed({{(GW+1){work[ch*DW+DW-1]}}, work[ch*DW +: DW]})
                * $signed({{DW{1'b0}}, gain});
    assign scaled[ch*DW +: DW] = DW'(prod >>> GW);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      fs_d       <= 1'b0;
      out_strobe <= 1'b0;
      data_out   <= '0;
    end else begin
      fs_d       <= fs;
      out_strobe <= fs_d;
      if (fs_d) data_out <= scaled;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      isi_m     <= 1'b0;
      isi_q     <= 1'b0;
      mis_m     <= 1'b0;
      mis_q     <= 1'b0;
      isi_sel_s <= 1'b0;
      mis_sel_s <= 1'b0;
    end else begin
      isi_m <= ISI_SEL;
      isi_q <= isi_m;
      mis_m <= MIS_SEL;
      mis_q <= mis_m;
      if (fs) begin
        isi_sel_s <= isi_q;
        mis_sel_s <= mis_q;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_dig_ctrl.sv
// Self-checking bench for audio_dac_dig_ctrl with a frame-level reference model.
module tb_audio_dac_dig_ctrl;

  localparam int NCH   = 2;
  localparam int DW    = 24;
  localparam int DB    = 5;
  localparam int GW    = 8;
  localparam int NEN   = DB - 2;
  localparam int FRAME = 1 << DB;
  localparam int UNITY = 1 << GW;

  logic              clock = 1'b0;
  logic              rstn;
  logic [NCH*DW-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mute_req;
  logic              isi, mis;
  logic [NEN-1:0]    clk_en, clk_en_neg;
  logic [DB-1:0]     div_cnt;
  logic [NCH*DW-1:0] data_out;
  logic              out_strobe, isi_sel_s, mis_sel_s, muted, underrun;
  logic [7:0]        underrun_cnt;

  audio_dac_dig_ctrl #(.NCH(NCH), .DW(DW), .DIV_BITS(DB), .GW(GW)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mute_req     (mute_req),
    .ISI_SEL      (isi),
    .MIS_SEL      (mis),
    .clk_en       (clk_en),
    .clk_en_neg   (clk_en_neg),
    .div_cnt      (div_cnt),
    .data_out     (data_out),
    .out_strobe   (out_strobe),
    .isi_sel_s    (isi_sel_s),
    .mis_sel_s    (mis_sel_s),
    .muted        (muted),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour
  int                m_cnt, m_gain, m_ucnt;
  bit                m_rdy, m_full, m_muted, m_under, m_fsd, m_strobe, m_isi, m_mis;
  bit                m_f, m_c;
  bit                isi_h[2], mis_h[2];
  logic [NCH*DW-1:0] m_buf, m_work, m_out;

  function automatic logic [NCH*DW-1:0] scale(input logic [NCH*DW-1:0] w, input int g);
    logic [NCH*DW-1:0] r;
    longint s, p, q;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      s = longint'($signed(w[c*DW +: DW]));
      p = s * g;
      q = (p >= 0) ? p / UNITY : -((-p + UNITY - 1) / UNITY);
      r[c*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0; m_gain = 0; m_ucnt = 0;
      m_rdy = 0; m_full = 0; m_muted = 1; m_under = 0;
      m_fsd = 0; m_strobe = 0; m_isi = 0; m_mis = 0;
      isi_h[0] = 0; isi_h[1] = 0; mis_h[0] = 0; mis_h[1] = 0;
      m_buf = '0; m_work = '0; m_out = '0;
    end else begin
      m_f = (m_cnt == FRAME - 1);
      m_c = in_valid && m_rdy && !m_full;
      m_strobe = m_fsd;
      if (m_fsd) m_out = scale(m_work, m_gain);
      m_fsd = m_f;
      if (m_f) begin
        if (m_full) begin
          m_work = m_buf;
          m_full = 0;
        end else begin
          m_under = 1;
          if (m_ucnt < 255) m_ucnt++;
        end
        if (mute_req && m_gain > 0) m_gain--;
        else if (!mute_req && m_gain < UNITY) m_gain++;
        m_isi = isi_h[1];
        m_mis = mis_h[1];
      end
      if (m_c) begin
        m_buf  = in_data;
        m_full = 1;
      end
      isi_h[1] = isi_h[0]; isi_h[0] = isi;
      mis_h[1] = mis_h[0]; mis_h[0] = mis;
      m_muted = (m_gain == 0) && mute_req;
      m_rdy = 1;
      m_cnt = (m_cnt + 1) % FRAME;
    end
  end

  logic [NEN-1:0] e_en, e_neg;
  always @(negedge clock) begin
    for (int k = 0; k < NEN; k++) begin
      e_en[k]  = ((m_cnt + 1) % (8 << k)) == 0;
      e_neg[k] = (m_cnt % (8 << k)) == ((4 << k) - 1);
    end
    chk("div_cnt", div_cnt, m_cnt);
    chk("clk_en", clk_en, e_en);
    chk("clk_en_neg", clk_en_neg, e_neg);
    chk("in_ready", in_ready, m_rdy && !m_full);
    chk("data_out", data_out, m_out);
    chk("out_strobe", out_strobe, m_strobe);
    chk("muted", muted, m_muted);
    chk("underrun", underrun, m_under);
    chk("underrun_cnt", underrun_cnt, m_ucnt);
    chk("isi_sel_s", isi_sel_s, m_isi);
    chk("mis_sel_s", mis_sel_s, m_mis);
    if (out_strobe) n_strobe++;
  end

  // Feeder: offers one frame whenever the block is ready.
  bit        feed_on = 0;
  logic [DW-1:0] feed_d0 = 24'h400000;
  logic [DW-1:0] feed_d1 = 24'hEDCBAA;
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(negedge clock);
      in_valid = feed_on && (in_ready === 1'b1);
      in_data  = {feed_d1, feed_d0};
    end
  end

  task automatic wait_strobes(input int target);
    int budget;
    budget = (target - n_strobe + 1) * FRAME * 2 + 64;
    while (n_strobe < target && budget > 0) begin
      @(negedge clock); #1;
      budget--;
    end
    if (n_strobe < target) chk("strobe_timeout", n_strobe, target);
  endtask

  task automatic wait_pos(input int p);
    int budget;
    budget = FRAME * 2;
    do begin
      @(negedge clock); #1;
      budget--;
    end while (m_cnt != p && budget > 0);
    if (m_cnt != p) chk("pos_timeout", m_cnt, p);
  endtask

  initial begin
    int n0, nf, last0, lag, base;
    mute_req = 1'b0;
    isi = 1'b0;
    mis = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_muted", muted, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_div_cnt", div_cnt, 0);
    #1 rstn = 1'b1;
    feed_on = 1;
    @(negedge clock);
    chk("ready_after_release", in_ready, 1);

    // ramp up from reset: first frame at gain 1
    wait_strobes(1);
    chk("gain1_ch0", data_out[23:0], 24'h004000);
    chk("gain1_ch1", data_out[47:24], 24'hFFEDCB);

    n0 = 0; nf = 0; last0 = -1; lag = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock); #1;
      if (clk_en[0]) begin n0++; last0 = i; end
      if (clk_en[NEN-1]) nf++;
      if (clk_en_neg[0] && last0 >= 0) lag = i - last0;
    end
    chk("clk_en0_count", n0, 8);
    chk("fs_count", nf, 2);
    chk("neg_lag", lag, 4);

    wait_strobes(256);
    chk("unity_out", data_out, {24'hEDCBAA, 24'h400000});
    chk("no_underrun", underrun, 0);

    // 100 frames of mute, then release
    wait_pos(10); mute_req = 1'b1;
    base = n_strobe;
    wait_strobes(base + 100);
    chk("gain156_ch0", data_out[23:0], 24'h270000);
    chk("ramp_not_muted", muted, 0);
    wait_pos(10); mute_req = 1'b0;
    base = n_strobe;
    wait_strobes(base + 100);
    chk("back_to_unity", data_out[23:0], 24'h400000);

    // bypass selects
    wait_pos(10); isi = 1'b1; mis = 1'b1;
    chk("isi_before_fs", isi_sel_s, 0);
    wait_strobes(n_strobe + 1);
    chk("isi_after_fs", isi_sel_s, 1);
    chk("mis_after_fs", mis_sel_s, 1);

    // underrun: one buffered frame drains, then three empty frames
    wait_pos(10); feed_on = 0;
    base = n_strobe;
    wait_strobes(base + 4);
    chk("underrun_flag", underrun, 1);
    chk("underrun_cnt3", underrun_cnt, 3);
    chk("underrun_hold", data_out, {24'hEDCBAA, 24'h400000});

    wait_pos(10);
    feed_d0 = 24'hFFFFFF; feed_d1 = 24'h7FFFFF; feed_on = 1;
    base = n_strobe;
    wait_strobes(base + 1);
    chk("fullscale_unity", data_out, {24'h7FFFFF, 24'hFFFFFF});

    wait_pos(10); mute_req = 1'b1;
    base = n_strobe;
    wait_strobes(base + 128);
    chk("minus1_gain128", data_out[23:0], 24'hFFFFFF);
    chk("max_gain128", data_out[47:24], 24'h3FFFFF);
    wait_strobes(base + 256);
    chk("gain0_out", data_out, 0);
    chk("muted_at_0", muted, 1);

    // reset mid-ramp while a frame is being offered
    wait_pos(10); mute_req = 1'b0;
    base = n_strobe;
    wait_strobes(base + 20);
    wait_pos(FRAME - 1);
    @(negedge clock); #1;
    chk("capture_offered", in_valid, 1);
    rstn = 1'b0;
    feed_on = 0;
    #1;
    chk("arst_data_out", data_out, 0);
    chk("arst_strobe", out_strobe, 0);
    chk("arst_muted", muted, 1);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ucnt", underrun_cnt, 0);
    chk("arst_div_cnt", div_cnt, 0);
    chk("arst_clk_en", clk_en, 0);
    chk("arst_isi", isi_sel_s, 0);
    repeat (2) @(negedge clock);
    #2 rstn = 1'b1;
    chk("release_ready_low", in_ready, 0);
    @(negedge clock);
    chk("release_ready_high", in_ready, 1);
    repeat (100) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/audio_dac_dig_ctrl.md
AUDIO_DAC_DIG_CTRL -- requirements
Module: audio_dac_dig_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, audio channel count.
REQ-002 SHALL have parameter DW, default 24, signed sample width.
REQ-003 SHALL have parameter DIV_BITS, default 10, divider width; NEN = DIV_BITS-2 enable taps; frame rate = clock/2^DIV_BITS.
REQ-004 SHALL have parameter GW, default 8, gain fraction bits; unity gain = 2^GW.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: ports clock and rstn.
REQ-006 clock  in  1  master clock, 49.152 MHz nominal.
REQ-007 rstn  in  1  asynchronous active-low reset.
REQ-008 in_data  in  NCH*DW  packed signed samples; channel 0 in the LSBs.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_ready  out  1  block can accept one frame.
REQ-011 mute_req  in  1  level-sensitive; 1 requests soft mute.
REQ-012 ISI_SEL, MIS_SEL  in  1 each  asynchronous DEM bypass selects.
REQ-013 clk_en, clk_en_neg  out  NEN each  single-cycle enable strobes.
REQ-014 div_cnt  out  DIV_BITS  free-running divider count.
REQ-015 data_out  out  NCH*DW  gain-scaled samples; out_strobe  out  1  data_out updated this cycle.
REQ-016 isi_sel_s, mis_sel_s  out  1 each  synchronised bypass selects; muted  out  1; underrun  out  1 (sticky); underrun_cnt  out  8.

Function
REQ-017 div_cnt SHALL increment by 1 every clock and wrap from 2^DIV_BITS-1 to 0.
REQ-018 clk_en[k] SHALL be high for exactly one cycle when div_cnt[k+2:0] is all ones (k=0 -> /8, k=NEN-1 -> /2^DIV_BITS).
REQ-019 clk_en_neg[k] SHALL be high for exactly one cycle when div_cnt[k+2] = 0 and div_cnt[k+1:0] is all ones (half-period offset).
REQ-020 Frame strobe fs SHALL be clk_en[NEN-1].
REQ-021 in_ready SHALL be 1 when the one-frame holding buffer is empty; a frame SHALL be captured when in_valid and in_ready are both 1 in the same cycle.
REQ-022 On fs, a full buffer SHALL transfer to the working register and become empty; a capture in the same cycle as fs SHALL be transferred to the working register at the next fs.
REQ-023 On fs with an empty buffer, the working register SHALL hold its previous value, underrun SHALL be set, and underrun_cnt SHALL increment, saturating at 255.
REQ-024 Mute FSM states: UNMUTED, RAMP_DOWN, MUTED, RAMP_UP; the gain register SHALL be GW+1 bits wide.
REQ-025 UNMUTED (gain 2^GW) SHALL go to RAMP_DOWN on mute_req=1.
REQ-026 RAMP_DOWN SHALL decrement gain by 1 per fs and enter MUTED when gain reaches 0.
REQ-027 MUTED SHALL go to RAMP_UP on mute_req=0.
REQ-028 RAMP_UP SHALL increment gain by 1 per fs and enter UNMUTED when gain reaches 2^GW.
REQ-029 A mute_req change during a ramp SHALL reverse direction from the current gain without a jump.
REQ-030 muted SHALL be 1 only in the MUTED state.
REQ-031 Per channel: product = sample*gain, a DW+GW+1 bit signed product; result = product arithmetically shifted right by GW (floor).
REQ-032 At unity gain the result SHALL equal the input exactly; at gain 0 the result SHALL be 0.
REQ-033 Latency: data_out SHALL update and out_strobe SHALL pulse 2 clocks after fs (register stage, then multiply stage).
REQ-034 ISI_SEL and MIS_SEL SHALL pass through a 2-flop synchroniser and update isi_sel_s and mis_sel_s only on fs.

Reset
REQ-035 While rstn = 0, asynchronously: div_cnt=0, clk_en=0, clk_en_neg=0, buffer empty, in_ready=0, working register=0, data_out=0, out_strobe=0, state=MUTED, gain=0, muted=1, underrun=0, underrun_cnt=0, isi_sel_s=0, mis_sel_s=0.
REQ-036 in_ready SHALL go to 1 one cycle after reset release; a reset during a ramp SHALL abort it to MUTED.
REQ-037 After reset, the block SHALL leave MUTED only via RAMP_UP, giving a click-free start.

Structure
REQ-038 Package audio_dac_pkg SHALL hold the mute state enum and the default DW, GW and DIV_BITS constants.
REQ-039 The divider and enable logic SHALL be the sub-module audio_dac_clk_en_gen (parameter DIV_BITS).

Verification
REQ-040 Reset release with DIV_BITS=10: clk_en[0] pulses every 8 cycles, clk_en[7] every 1024 cycles; clk_en_neg[0] lags clk_en[0] by 4 cycles.
REQ-041 mute_req=0 from reset, in_data=0x400000 every frame: gain 1 -> 256 over 256 frames, then data_out = 0x400000 exactly.
REQ-042 UNMUTED, mute_req=1 for 100 frames then 0: gain falls to 156 then rises back to 256 with no step; muted stays 0.
REQ-043 in_data = -1 at gain 128: data_out = -1 (floor); in_data = 0x7FFFFF at gain 256: data_out = 0x7FFFFF.
REQ-044 in_valid held low for 3 frames: data_out holds its last value, underrun=1, underrun_cnt=3.
REQ-045 rstn asserted mid-ramp and mid-capture: all outputs match REQ-035 immediately and in_ready = 1 one cycle after release.
